// File: rtl/evaluate_blend_pkg.sv
// evaluate_pkg: states, default constants and helpers shared by the evaluation blend.
package evaluate_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_TERMS, PIPE, HOLD} state_e;
   localparam int DEF_PHASE_MAX = 62;
   localparam int DEF_FRAC_BITS = 20;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic longint recip(input int frac, input int pmax);
      return (longint'(1) << frac) / longint'(pmax);
   endfunction
   // Symmetric clamp so a later negation can never overflow.
   function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int w);
      logic signed [127:0] lim;
      lim = (128'sd1 <<< (w - 1)) - 128'sd1;
      return (v > lim) ? lim : (v < -lim) ? -lim : v;
   endfunction
endpackage

// File: rtl/evaluate_blend_if.sv
// evaluate_blend_if: term collection and result bus of the evaluation blend.
interface evaluate_blend_if #(parameter int EVAL_WIDTH = 24, parameter int NUM_TERMS = 8);
   logic                            start;
   logic [6:0]                      occupied_count;
   logic                            negate_for_side;
   logic [NUM_TERMS-1:0]            term_mask;
   logic [NUM_TERMS*EVAL_WIDTH-1:0] term_mg;
   logic [NUM_TERMS*EVAL_WIDTH-1:0] term_eg;
   logic [NUM_TERMS-1:0]            term_valid;
   logic                            clear_eval;
   logic signed [EVAL_WIDTH-1:0]    eval;
   logic                            eval_valid;
   logic                            timeout_err;
   logic                            busy;
   modport master (
      output start, occupied_count, negate_for_side, term_mask, term_mg, term_eg, term_valid, clear_eval,
      input  eval, eval_valid, timeout_err, busy
   );
   modport slave (
      input  start, occupied_count, negate_for_side, term_mask, term_mg, term_eg, term_valid, clear_eval,
      output eval, eval_valid, timeout_err, busy
   );
endinterface

// File: rtl/evaluate_blend_adder_tree.sv
// eval_adder_tree: pipelined signed reduction of N inputs, one registered level per stage.
module eval_adder_tree
   import evaluate_pkg::*;
#(
   parameter int  N    = 8,
   parameter int  IN_W = 24,
   localparam int S    = clog2(N),
   localparam int OW   = IN_W + S
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*IN_W-1:0]    din,
   output logic signed [OW-1:0] sum
);
   localparam int P = 1 << S;
   // Heap layout: node k sums children 2k and 2k+1, leaves sit at P..2P-1.
   logic signed [OW-1:0] lvl [1:2*P-1];
   logic signed [OW-1:0] node_d [1:P-1];
   logic signed [OW-1:0] node_q [1:P-1];
   always_comb begin
      lvl = '{default: '0};
      for (int k = 1; k < P; k++) lvl[k] = node_q[k];
      for (int k = 0; k < N; k++) lvl[P+k] = OW'(signed'(din[k*IN_W +: IN_W]));
      for (int k = 1; k < P; k++) node_d[k] = lvl[2*k] + lvl[2*k+1];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) node_q <= '{default: '0};
      else node_q <= node_d;
   end
   assign sum = node_q[1];
endmodule

// File: rtl/evaluate_blend.sv
// evaluate_blend: tapered mg/eg evaluation combiner; collects terms, blends by phase,
// rescales by a reciprocal multiply, then truncates, negates and saturates.
module evaluate_blend
   import evaluate_pkg::*;
#(
   parameter int EVAL_WIDTH = 24,
   parameter int NUM_TERMS  = 8,
   parameter int PHASE_MAX  = DEF_PHASE_MAX,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int TIMEOUT    = 255
) (
   input logic             clk,
   input logic             reset,
   evaluate_blend_if.slave bus
);
   localparam int TS    = clog2(NUM_TERMS);
   localparam int LAT   = TS + 4;
   localparam int SUM_W = EVAL_WIDTH + TS;
   localparam int MW    = SUM_W + 8;
   localparam int SC_W  = MW + 1;
   localparam int PR_W  = SC_W + FRAC_BITS + 2;
   localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int LW    = $clog2(LAT);
   localparam int EW    = EVAL_WIDTH;
   localparam logic signed [FRAC_BITS+1:0] RECIP = (FRAC_BITS+2)'(recip(FRAC_BITS, PHASE_MAX));
   localparam logic [6:0] PMAX = 7'(PHASE_MAX);

   state_e                      state_q, state_d;
   logic                        start_q;
   logic [6:0]                  phase_q, phase_d;
   logic [NUM_TERMS-1:0]        mask_q, mask_d;
   logic                        neg_q, neg_d;
   logic [TW-1:0]               tmo_q, tmo_d;
   logic [LW-1:0]               lat_q, lat_d;
   logic [NUM_TERMS*EW-1:0]     mg_in_q, mg_in_d, eg_in_q, eg_in_d;
   logic signed [SUM_W-1:0]     mg_sum, eg_sum;
   logic signed [MW-1:0]        mg_s_q, mg_s_d, eg_s_q, eg_s_d;
   logic signed [SC_W-1:0]      score_q, score_d;
   logic signed [PR_W-1:0]      prod_q, prod_d, q;
   logic signed [EW-1:0]        eval_q, eval_d, eval_sat;
   logic                        valid_q, terr_q, terr_d, busy_q;
   logic                        all_ok, tmo_hit;

   eval_adder_tree #(.N(NUM_TERMS), .IN_W(EW)) u_mg_tree (.clk(clk), .rst_n(reset), .din(mg_in_q), .sum(mg_sum));
   eval_adder_tree #(.N(NUM_TERMS), .IN_W(EW)) u_eg_tree (.clk(clk), .rst_n(reset), .din(eg_in_q), .sum(eg_sum));

   assign all_ok  = &(bus.term_valid | ~mask_q);
   assign tmo_hit = (TIMEOUT != 0) && ({1'b0, tmo_q} + (TW+1)'(1) == (TW+1)'(TIMEOUT));

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      mask_d  = mask_q;
      neg_d   = neg_q;
      tmo_d   = tmo_q;
      lat_d   = lat_q;
      eval_d  = eval_q;
      terr_d  = terr_q;
      mg_in_d = mg_in_q;
      eg_in_d = eg_in_q;
      if (bus.clear_eval && state_q != IDLE) begin
         state_d = IDLE;
         terr_d  = 1'b0;
      end else if (state_q == IDLE && bus.start && !start_q) begin
         state_d = WAIT_TERMS;
         phase_d = (bus.occupied_count > PMAX) ? PMAX : bus.occupied_count;
         mask_d  = bus.term_mask;
         neg_d   = bus.negate_for_side;
         tmo_d   = '0;
      end else if (state_q == WAIT_TERMS && all_ok) begin
         state_d = PIPE;
         lat_d   = LW'(LAT - 1);
         for (int i = 0; i < NUM_TERMS; i++) begin
            mg_in_d[i*EW +: EW] = mask_q[i] ? bus.term_mg[i*EW +: EW] : '0;
            eg_in_d[i*EW +: EW] = mask_q[i] ? bus.term_eg[i*EW +: EW] : '0;
         end
      end else if (state_q == WAIT_TERMS) begin
         tmo_d   = tmo_q + TW'(1);
         state_d = tmo_hit ? HOLD : WAIT_TERMS;
         eval_d  = tmo_hit ? '0 : eval_q;
         terr_d  = tmo_hit;
      end else if (state_q == PIPE) begin
         lat_d   = lat_q - LW'(1);
         state_d = (lat_q == '0) ? HOLD : PIPE;
         eval_d  = (lat_q == '0) ? eval_sat : eval_q;
      end
   end

   // Datapath runs freely; the LAT down-counter decides when its output is meaningful.
   always_comb begin
      mg_s_d   = MW'(mg_sum) * MW'($signed({1'b0, phase_q}));
      eg_s_d   = MW'(eg_sum) * MW'($signed({1'b0, PMAX - phase_q}));
      score_d  = SC_W'(mg_s_q) + SC_W'(eg_s_q);
      prod_d   = PR_W'(score_q) * PR_W'(RECIP);
      q        = prod_q >>> FRAC_BITS;
      q        = (prod_q[PR_W-1] && |prod_q[FRAC_BITS-1:0]) ? q + PR_W'(1) : q;
      q        = neg_q ? -q : q;
      eval_sat = EW'(saturate(128'(q), EW));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         phase_q <= '0;
         mask_q  <= '0;
         neg_q   <= 1'b0;
         tmo_q   <= '0;
         lat_q   <= '0;
         mg_in_q <= '0;
         eg_in_q <= '0;
         mg_s_q  <= '0;
         eg_s_q  <= '0;
         score_q <= '0;
         prod_q  <= '0;
         eval_q  <= '0;
         terr_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= bus.start;
         phase_q <= phase_d;
         mask_q  <= mask_d;
         neg_q   <= neg_d;
         tmo_q   <= tmo_d;
         lat_q   <= lat_d;
         mg_in_q <= mg_in_d;
         eg_in_q <= eg_in_d;
         mg_s_q  <= mg_s_d;
         eg_s_q  <= eg_s_d;
         score_q <= score_d;
         prod_q  <= prod_d;
         eval_q  <= eval_d;
         terr_q  <= terr_d;
         valid_q <= (state_d == HOLD);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign bus.eval        = eval_q;
   assign bus.eval_valid  = valid_q;
   assign bus.timeout_err = terr_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_evaluate_blend.sv
// tb_evaluate_blend: directed vectors into a scoreboard queue; a monitor pops on each
// eval_valid rise, compares result/error/latency, then clears the hold.
module tb_evaluate_blend;
   localparam int EW  = 16;
   localparam int NT  = 4;
   localparam int TMO = 10;
   localparam int LAT = 6;

   typedef struct {
      string name;
      int    ev;
      bit    te;
      int    at;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic clr_mon = 1'b0;
   logic clr_stim = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb[$];

   evaluate_blend_if #(.EVAL_WIDTH(EW), .NUM_TERMS(NT)) bus ();

   evaluate_blend #(
      .EVAL_WIDTH(EW), .NUM_TERMS(NT), .PHASE_MAX(62), .FRAC_BITS(20), .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   assign bus.clear_eval = clr_mon | clr_stim;

   always #5 clk = ~clk;
   initial forever @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic drive(input logic [63:0] mg, input logic [63:0] eg, input int occ, input bit neg,
                        input logic [3:0] mask, input logic [3:0] valid);
      bus.term_mg         = mg;
      bus.term_eg         = eg;
      bus.occupied_count  = 7'(occ);
      bus.negate_for_side = neg;
      bus.term_mask       = mask;
      bus.term_valid      = valid;
   endtask

   task automatic expect_res(input string name, input int ev, input bit te);
      exp_t e;
      e.name = name;
      e.ev   = ev;
      e.te   = te;
      e.at   = cyc + (te ? TMO + 1 : LAT + 2);
      sb.push_back(e);
   endtask

   task automatic pulse_start;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.busy && !bus.eval_valid) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s idle: still busy after 100 cycles, expected idle", name);
   endtask

   task automatic run(input string name, input logic [63:0] mg, input logic [63:0] eg, input int occ,
                      input bit neg, input logic [3:0] mask, input logic [3:0] valid,
                      input int ev, input bit te);
      @(negedge clk);
      drive(mg, eg, occ, neg, mask, valid);
      expect_res(name, ev, te);
      pulse_start();
      wait_idle(name);
   endtask

   initial begin
      bit   pv;
      exp_t e;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         clr_mon = 1'b0;
         if (bus.eval_valid && !pv) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected eval_valid: got eval %0d, expected no result", bus.eval);
            end else begin
               e = sb.pop_front();
               check({e.name, " eval"}, longint'(bus.eval), e.ev);
               check({e.name, " timeout_err"}, bus.timeout_err, e.te);
               check({e.name, " valid cycle"}, cyc, e.at);
            end
            clr_mon = 1'b1;
         end
         pv = bus.eval_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      drive('0, '0, 0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      check("reset eval", longint'(bus.eval), 0);
      check("reset eval_valid", bus.eval_valid, 0);
      check("reset timeout_err", bus.timeout_err, 0);
      check("reset busy", bus.busy, 0);
      reset = 1'b1;

      run("basic", pack4(40, 30, 20, 10), pack4(50, 50, 50, 50), 31, 1'b0, 4'hf, 4'hf, 149, 1'b0);
      run("neg trunc", pack4(-40, -30, -20, -10), pack4(-50, -50, -50, -50), 31, 1'b0, 4'hf, 4'hf, -149, 1'b0);
      run("phase clamp", pack4(25, 25, 25, 25), pack4(50, 50, 50, 50), 64, 1'b0, 4'hf, 4'hf, 99, 1'b0);
      run("clamp negate", pack4(25, 25, 25, 25), pack4(50, 50, 50, 50), 64, 1'b1, 4'hf, 4'hf, -99, 1'b0);
      run("mask", pack4(10, 20, 1000, 30), pack4(20, 40, 1000, 60), 62, 1'b0, 4'b1011, 4'b1011, 59, 1'b0);
      run("mask zero", pack4(1000, 1000, 1000, 1000), pack4(1000, 1000, 1000, 1000), 20, 1'b0, 4'h0, 4'h0, 0, 1'b0);
      run("timeout", pack4(40, 30, 20, 10), pack4(50, 50, 50, 50), 31, 1'b0, 4'hf, 4'b1101, 0, 1'b1);
      check("timeout cleared err", bus.timeout_err, 0);
      check("timeout cleared valid", bus.eval_valid, 0);
      run("sat pos", pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 0, 1'b0, 4'hf, 4'hf, 32767, 1'b0);
      run("sat neg", pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 0, 1'b1, 4'hf, 4'hf, -32767, 1'b0);

      @(negedge clk);
      drive(pack4(40, 30, 20, 10), pack4(50, 50, 50, 50), 31, 1'b0, 4'hf, 4'hf);
      pulse_start();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid reset eval", longint'(bus.eval), 0);
      check("mid reset eval_valid", bus.eval_valid, 0);
      check("mid reset timeout_err", bus.timeout_err, 0);
      check("mid reset busy", bus.busy, 0);
      @(negedge clk);
      reset = 1'b1;
      run("after reset", pack4(40, 30, 20, 10), pack4(50, 50, 50, 50), 31, 1'b0, 4'hf, 4'hf, 149, 1'b0);

      @(negedge clk);
      drive(pack4(40, 30, 20, 10), pack4(50, 50, 50, 50), 31, 1'b0, 4'hf, 4'hf);
      expect_res("start held", 149, 1'b0);
      bus.start = 1'b1;
      repeat (20) @(negedge clk);
      bus.start = 1'b0;
      wait_idle("start held");

      @(negedge clk);
      pulse_start();
      repeat (2) @(negedge clk);
      clr_stim = 1'b1;
      @(negedge clk);
      clr_stim = 1'b0;
      check("abort busy", bus.busy, 0);
      repeat (12) @(negedge clk);
      check("abort eval_valid", bus.eval_valid, 0);

      repeat (3) @(negedge clk);
      check("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
